l1_snp_rsp_ctrl: RTL and testbench
==================================

# l1_snp_rsp_ctrl

L1 snoop responder: the upstream-facing counterpart of the L1 request controller. It accepts snoop requests arriving from the bus (SUREQ), looks up the block's MESI+MIGRATED state, and returns a snoop response (SDRSP), flushing dirty data when required. It commits the snooped block's next state into the state array. It sits between the bus snoop port and the L1 tag/state/data arrays, alongside the L1 request controller.

## Interface
Parameters:
- ADDR_WIDTH, 32, snoop address width
- DATA_WIDTH, 32, cache block data width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; asynchronous, active-high
- sureq_valid  in  1  snoop request valid
- sureq_ready  out  1  snoop request accepted when valid&ready
- sureq_op  in  2  SUREQ_RD / SUREQ_RFO / SUREQ_INV
- sureq_addr  in  ADDR_WIDTH  snooped block address
- req_lock  in  1  L1 request controller is mid-transaction; blocks acceptance
- tag_rd_en  out  1  tag/state lookup strobe
- tag_rd_addr  out  ADDR_WIDTH  lookup address
- tag_hit  in  1  lookup hit, valid the cycle after tag_rd_en
- tag_blk_st  in  3  block state, valid with tag_hit
- data_rd_en  out  1  data array read strobe
- data_rd_addr  out  ADDR_WIDTH  data read address
- data_rd_data  in  DATA_WIDTH  read data, valid the cycle after data_rd_en
- blk_wr_en  out  1  state-array write strobe
- blk_wr_addr  out  ADDR_WIDTH  state write address
- blk_nxtSt  out  3  state to write
- sdrsp_valid  out  1  snoop response valid
- sdrsp_ready  in  1  bus accepts response
- sdrsp_rsp  out  2  SDRSP_MISS / SDRSP_OKAY / SDRSP_DATA
- sdrsp_data  out  DATA_WIDTH  flushed block; 0 unless sdrsp_rsp==SDRSP_DATA

## Operation
- FSM states: SNP_IDLE, SNP_LOOKUP, SNP_DATA, SNP_SEND_RSP.
- SNP_IDLE: sureq_ready = !req_lock. On handshake, latch op/addr, pulse tag_rd_en with tag_rd_addr=sureq_addr, go to SNP_LOOKUP.
- SNP_LOOKUP: evaluate tag_hit/tag_blk_st. A miss, or a hit in INVALID, gives SDRSP_MISS with no state write. A dirty hit (MODIFIED/MIGRATED) on RD/RFO pulses data_rd_en and goes to SNP_DATA. Every other case goes to SNP_SEND_RSP with SDRSP_OKAY.
- SNP_DATA: capture data_rd_data into the response register, go to SNP_SEND_RSP with SDRSP_DATA.
- SNP_SEND_RSP: hold sdrsp_valid and all response fields stable until sdrsp_ready. On the handshake cycle, pulse blk_wr_en (except on a miss) and return to SNP_IDLE.
- Next state, RD: M/MIG->SHARED; E->SHARED; S->SHARED.
- Next state, RFO: any valid state->INVALID.
- Next state, INV: any valid state->INVALID, SDRSP_OKAY, never data. INV to E/M/MIG is illegal and is treated as a plain INV.
- The state write happens only at the response handshake. The array is never updated before the bus owns the response.

## Timing
- Reset: all outputs 0 (sureq_ready 0 while rst is high); FSM goes to SNP_IDLE; response registers clear.
- Clean/miss path: handshake at cycle 0, lookup at cycle 1, sdrsp_valid at cycle 2.
- Dirty path: data_rd_en at cycle 1, data captured at cycle 2, sdrsp_valid at cycle 3.
- If sdrsp_ready is already high when sdrsp_valid rises, the transaction completes that cycle. sureq_ready is reasserted the next cycle, so the throughput ceiling is one snoop per 3 cycles (clean).
- sureq_ready is 0 in all non-IDLE states. A new request is never accepted in the same cycle as a response handshake.
- req_lock rising while not in IDLE has no effect on the current snoop.
- rst mid-transaction: the snoop is abandoned, no blk_wr_en, and no response is emitted.

## Configuration
- Macro L1_SNP_FWD_CLEAN_EN:
  - Defined: RD/RFO hits in EXCLUSIVE or SHARED also read data (SNP_DATA path) and respond SDRSP_DATA, giving cache-to-cache forwarding.
  - Undefined: clean hits respond SDRSP_OKAY with sdrsp_data=0.
- State transitions are identical either way.

## Structure
- In cache_pkg:
  - SUREQ_* and SDRSP_* encodings.
  - The snoop FSM state enum (SNP_*).
  - Reuse of the existing block-state constants (INVALID, SHARED, EXCLUSIVE, MODIFIED, MIGRATED).
- Sub-module fsm_l1_snp_nxtst: pure combinational (op, hit, blk_st) -> {blk_nxtSt, rsp, need_data}. This sub-module is the only place the transition rules live.

## Test plan
- Reset with sureq_valid=1: sureq_ready=0 and all outputs 0. After reset release with req_lock=0, sureq_ready=1.
- SUREQ_RD to addr 0x40, hit MODIFIED, data 0xDEADBEEF, sdrsp_ready=1: at cycle 3 sdrsp_rsp=SDRSP_DATA, sdrsp_data=0xDEADBEEF, blk_wr_en with blk_nxtSt=SHARED.
- SUREQ_RFO to 0x80, hit EXCLUSIVE, sdrsp_ready held 0 for 4 cycles: the response stays stable, and blk_wr_en (INVALID) fires only on the cycle sdrsp_ready=1. Under L1_SNP_FWD_CLEAN_EN, expect SDRSP_DATA instead.
- SUREQ_INV to 0xC0, tag_hit=0: SDRSP_MISS at cycle 2, no blk_wr_en.
- req_lock=1 with sureq_valid=1 for 5 cycles: no acceptance and no tag_rd_en. Acceptance occurs the cycle after req_lock drops.
- Assert rst during SNP_DATA: no sdrsp_valid and no blk_wr_en. The next snoop after reset completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared L1 cache encodings: block states, snoop request/response codes and the
// snoop-responder FSM state type.
package cache_pkg;

    localparam int unsigned BLK_ST_W = 3;
    localparam int unsigned SUREQ_W  = 2;
    localparam int unsigned SDRSP_W  = 2;

    // MESI + MIGRATED block states
    localparam logic [BLK_ST_W-1:0] INVALID   = 3'd0;
    localparam logic [BLK_ST_W-1:0] SHARED    = 3'd1;
    localparam logic [BLK_ST_W-1:0] EXCLUSIVE = 3'd2;
    localparam logic [BLK_ST_W-1:0] MODIFIED  = 3'd3;
    localparam logic [BLK_ST_W-1:0] MIGRATED  = 3'd4;

    localparam logic [SUREQ_W-1:0] SUREQ_RD  = 2'd0;
    localparam logic [SUREQ_W-1:0] SUREQ_RFO = 2'd1;
    localparam logic [SUREQ_W-1:0] SUREQ_INV = 2'd2;

    localparam logic [SDRSP_W-1:0] SDRSP_MISS = 2'd0;
    localparam logic [SDRSP_W-1:0] SDRSP_OKAY = 2'd1;
    localparam logic [SDRSP_W-1:0] SDRSP_DATA = 2'd2;

    typedef enum logic [1:0] {
        SNP_IDLE     = 2'd0,
        SNP_LOOKUP   = 2'd1,
        SNP_DATA     = 2'd2,
        SNP_SEND_RSP = 2'd3
    } snp_state_e;

endpackage

// File: rtl/fsm_l1_snp_nxtst.sv
// Snoop transition rules: (op, hit, blk_st) -> next block state, response code and
// whether the block data must be read. Option: L1_SNP_FWD_CLEAN_EN forwards clean data.
module fsm_l1_snp_nxtst
    import cache_pkg::*;
(
    input  logic [SUREQ_W-1:0]  op,
    input  logic                hit,
    input  logic [BLK_ST_W-1:0] blk_st,
    output logic [BLK_ST_W-1:0] blk_nxtSt,
    output logic [SDRSP_W-1:0]  rsp,
    output logic                need_data
);

`ifdef L1_SNP_FWD_CLEAN_EN
    localparam logic FWD_CLEAN = 1'b1;
`else
    localparam logic FWD_CLEAN = 1'b0;
`endif

    logic blk_dirty;
    logic blk_clean;

    assign blk_dirty = hit && ((blk_st == MODIFIED) || (blk_st == MIGRATED));
    assign blk_clean = hit && ((blk_st == EXCLUSIVE) || (blk_st == SHARED));

    always_comb begin
        blk_nxtSt = INVALID;
        rsp       = SDRSP_MISS;
        need_data = 1'b0;
        if (blk_dirty || blk_clean) begin
            unique case (op)
                SUREQ_RD: begin
                    blk_nxtSt = SHARED;
                    need_data = blk_dirty || (FWD_CLEAN && blk_clean);
                end
                SUREQ_RFO: begin
                    blk_nxtSt = INVALID;
                    need_data = blk_dirty || (FWD_CLEAN && blk_clean);
                end
                // INV (and the unused encoding) never moves data, whatever the state
                default: begin
                    blk_nxtSt = INVALID;
                    need_data = 1'b0;
                end
            endcase
            rsp = need_data ? SDRSP_DATA : SDRSP_OKAY;
        end
    end

endmodule

// File: rtl/l1_snp_rsp_ctrl.sv
// L1 snoop responder: accepts bus snoops, looks up block state, returns SDRSP and commits
// the next block state only at the response handshake. Option: L1_SNP_FWD_CLEAN_EN.
module l1_snp_rsp_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sureq_valid,
    output logic                  sureq_ready,
    input  logic [SUREQ_W-1:0]    sureq_op,
    input  logic [ADDR_WIDTH-1:0] sureq_addr,
    input  logic                  req_lock,
    output logic                  tag_rd_en,
    output logic [ADDR_WIDTH-1:0] tag_rd_addr,
    input  logic                  tag_hit,
    input  logic [BLK_ST_W-1:0]   tag_blk_st,
    output logic                  data_rd_en,
    output logic [ADDR_WIDTH-1:0] data_rd_addr,
    input  logic [DATA_WIDTH-1:0] data_rd_data,
    output logic                  blk_wr_en,
    output logic [ADDR_WIDTH-1:0] blk_wr_addr,
    output logic [BLK_ST_W-1:0]   blk_nxtSt,
    output logic                  sdrsp_valid,
    input  logic                  sdrsp_ready,
    output logic [SDRSP_W-1:0]    sdrsp_rsp,
    output logic [DATA_WIDTH-1:0] sdrsp_data
);

    snp_state_e            state_q, state_d;
    logic [SUREQ_W-1:0]    op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SDRSP_W-1:0]    rsp_q, rsp_d;
    logic [BLK_ST_W-1:0]   nxtst_q, nxtst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [BLK_ST_W-1:0]   lk_nxtst;
    logic [SDRSP_W-1:0]    lk_rsp;
    logic                  lk_need_data;

    fsm_l1_snp_nxtst u_nxtst (
        .op        (op_q),
        .hit       (tag_hit),
        .blk_st    (tag_blk_st),
        .blk_nxtSt (lk_nxtst),
        .rsp       (lk_rsp),
        .need_data (lk_need_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SNP_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rsp_q   <= '0;
            nxtst_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rsp_q   <= rsp_d;
            nxtst_q <= nxtst_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rsp_d       = rsp_q;
        nxtst_d     = nxtst_q;
        data_d      = data_q;
        sureq_ready = 1'b0;
        tag_rd_en   = 1'b0;
        data_rd_en  = 1'b0;
        blk_wr_en   = 1'b0;
        sdrsp_valid = 1'b0;
        unique case (state_q)
            SNP_IDLE: begin
                // ready is held low while reset is asserted, even though the state is idle
                sureq_ready = !req_lock && !rst;
                if (sureq_valid && sureq_ready) begin
                    tag_rd_en = 1'b1;
                    op_d      = sureq_op;
                    addr_d    = sureq_addr;
                    state_d   = SNP_LOOKUP;
                end
            end
            SNP_LOOKUP: begin
                rsp_d   = lk_rsp;
                nxtst_d = lk_nxtst;
                data_d  = '0;
                if (lk_need_data) begin
                    data_rd_en = 1'b1;
                    state_d    = SNP_DATA;
                end else begin
                    state_d    = SNP_SEND_RSP;
                end
            end
            SNP_DATA: begin
                data_d  = data_rd_data;
                state_d = SNP_SEND_RSP;
            end
            SNP_SEND_RSP: begin
                sdrsp_valid = 1'b1;
                // the state array is only touched once the bus owns the response
                if (sdrsp_ready) begin
                    blk_wr_en = (rsp_q != SDRSP_MISS);
                    op_d      = '0;
                    addr_d    = '0;
                    rsp_d     = '0;
                    nxtst_d   = '0;
                    data_d    = '0;
                    state_d   = SNP_IDLE;
                end
            end
            default: state_d = SNP_IDLE;
        endcase
    end

    assign tag_rd_addr  = tag_rd_en  ? sureq_addr : '0;
    assign data_rd_addr = data_rd_en ? addr_q     : '0;
    assign blk_wr_addr  = blk_wr_en  ? addr_q     : '0;
    assign blk_nxtSt    = blk_wr_en  ? nxtst_q    : '0;
    assign sdrsp_rsp    = rsp_q;
    assign sdrsp_data   = data_q;

endmodule

// File: tb/tb_l1_snp_rsp_ctrl.sv
// Bench for l1_snp_rsp_ctrl: transaction-level reference model plus directed snoops
// and a randomized stream (honours L1_SNP_FWD_CLEAN_EN).
module tb_l1_snp_rsp_ctrl;
    import cache_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef L1_SNP_FWD_CLEAN_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sureq_valid = 1'b0;
    logic          sureq_ready;
    logic [1:0]    sureq_op = 2'd0;
    logic [AW-1:0] sureq_addr = '0;
    logic          req_lock = 1'b0;
    logic          tag_rd_en;
    logic [AW-1:0] tag_rd_addr;
    logic          tag_hit = 1'b0;
    logic [2:0]    tag_blk_st = 3'd0;
    logic          data_rd_en;
    logic [AW-1:0] data_rd_addr;
    logic [DW-1:0] data_rd_data = '0;
    logic          blk_wr_en;
    logic [AW-1:0] blk_wr_addr;
    logic [2:0]    blk_nxtSt;
    logic          sdrsp_valid;
    logic          sdrsp_ready = 1'b0;
    logic [1:0]    sdrsp_rsp;
    logic [DW-1:0] sdrsp_data;

    always #5 clk = ~clk;

    l1_snp_rsp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .sureq_valid(sureq_valid), .sureq_ready(sureq_ready),
        .sureq_op(sureq_op), .sureq_addr(sureq_addr), .req_lock(req_lock),
        .tag_rd_en(tag_rd_en), .tag_rd_addr(tag_rd_addr),
        .tag_hit(tag_hit), .tag_blk_st(tag_blk_st),
        .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
        .blk_wr_en(blk_wr_en), .blk_wr_addr(blk_wr_addr), .blk_nxtSt(blk_nxtSt),
        .sdrsp_valid(sdrsp_valid), .sdrsp_ready(sdrsp_ready),
        .sdrsp_rsp(sdrsp_rsp), .sdrsp_data(sdrsp_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // what the tag/data arrays will return for the request currently offered
    logic          plan_hit = 1'b0;
    logic [2:0]    plan_st = 3'd0;
    logic [DW-1:0] plan_data = '0;

    // reference model: one outstanding snoop, timed in cycles since acceptance
    bit            m_busy = 1'b0;
    int            m_k = 0;
    logic [1:0]    m_rsp = 2'd0;
    logic [2:0]    m_nxt = 3'd0;
    bit            m_need = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_hit = 1'b0;
    logic [2:0]    m_st = 3'd0;
    logic [DW-1:0] m_data = '0;
    bit            seen_tag = 1'b0;
    bit            seen_data = 1'b0;
    bit            acc_last = 1'b0;
    bit            e_ready, e_tag, e_den, e_valid, e_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_snoop(input logic [1:0] op, input logic hit, input logic [2:0] st,
                                      output logic [1:0] rsp, output logic [2:0] nxt, output bit need);
        bit present, dirty;
        present = hit && (st == SHARED || st == EXCLUSIVE || st == MODIFIED || st == MIGRATED);
        dirty   = (st == MODIFIED || st == MIGRATED);
        nxt  = INVALID;
        need = 1'b0;
        rsp  = SDRSP_MISS;
        if (present) begin
            if (op == SUREQ_RD) nxt = SHARED;
            if (op != SUREQ_INV) need = dirty || FWD;
            rsp = need ? SDRSP_DATA : SDRSP_OKAY;
        end
    endfunction

    // compare process: checks every output each cycle, then advances the model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_sureq_ready", 64'(sureq_ready), 64'(0));
            chk("rst_tag_rd_en",   64'(tag_rd_en),   64'(0));
            chk("rst_data_rd_en",  64'(data_rd_en),  64'(0));
            chk("rst_blk_wr_en",   64'(blk_wr_en),   64'(0));
            chk("rst_sdrsp_valid", 64'(sdrsp_valid), 64'(0));
            chk("rst_sdrsp_rsp",   64'(sdrsp_rsp),   64'(0));
            chk("rst_sdrsp_data",  64'(sdrsp_data),  64'(0));
            m_busy = 1'b0; seen_tag = 1'b0; seen_data = 1'b0; acc_last = 1'b0;
        end else begin
            e_ready = !m_busy && !req_lock;
            e_tag   = e_ready && sureq_valid;
            e_den   = m_busy && m_need && (m_k == 1);
            e_valid = m_busy && (m_k >= (m_need ? 3 : 2));
            e_wr    = e_valid && sdrsp_ready && (m_rsp != SDRSP_MISS);
            chk("sureq_ready", 64'(sureq_ready), 64'(e_ready));
            chk("tag_rd_en",   64'(tag_rd_en),   64'(e_tag));
            if (e_tag) chk("tag_rd_addr", 64'(tag_rd_addr), 64'(sureq_addr));
            chk("data_rd_en",  64'(data_rd_en),  64'(e_den));
            if (e_den) chk("data_rd_addr", 64'(data_rd_addr), 64'(m_addr));
            chk("sdrsp_valid", 64'(sdrsp_valid), 64'(e_valid));
            if (e_valid) begin
                chk("sdrsp_rsp",  64'(sdrsp_rsp),  64'(m_rsp));
                chk("sdrsp_data", 64'(sdrsp_data), m_need ? 64'(m_data) : 64'(0));
            end
            chk("blk_wr_en", 64'(blk_wr_en), 64'(e_wr));
            if (e_wr) begin
                chk("blk_wr_addr", 64'(blk_wr_addr), 64'(m_addr));
                chk("blk_nxtSt",   64'(blk_nxtSt),   64'(m_nxt));
            end
            seen_data = e_den;
            seen_tag  = e_tag;
            acc_last  = e_tag;
            if (e_valid && sdrsp_ready) m_busy = 1'b0;
            else if (m_busy) m_k++;
            if (e_tag) begin
                m_busy = 1'b1; m_k = 1;
                m_addr = sureq_addr; m_hit = plan_hit; m_st = plan_st; m_data = plan_data;
                ref_snoop(sureq_op, plan_hit, plan_st, m_rsp, m_nxt, m_need);
            end
        end
    end

    // array responder: real lookup/read results only the cycle after a strobe, noise otherwise
    always @(posedge clk) begin
        #1;
        tag_hit      = seen_tag  ? m_hit  : 1'($urandom);
        tag_blk_st   = seen_tag  ? m_st   : 3'($urandom);
        data_rd_data = seen_data ? m_data : DW'($urandom);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snoop(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic hit, input logic [2:0] st, input logic [DW-1:0] d,
                         input logic [1:0] x_rsp, input logic [DW-1:0] x_data, input bit x_wr,
                         input logic [2:0] x_nxt, input int x_cyc);
        step();
        req_lock = 1'b0; sdrsp_ready = 1'b1; sureq_valid = 1'b1;
        sureq_op = op; sureq_addr = addr; plan_hit = hit; plan_st = st; plan_data = d;
        @(negedge clk);
        chk({name, "_tag_rd_en"}, 64'(tag_rd_en), 64'(1));
        for (int c = 1; c <= x_cyc; c++) begin
            step();
            sureq_valid = 1'b0;
            @(negedge clk);
            if (c < x_cyc) begin
                chk({name, "_early_valid"}, 64'(sdrsp_valid), 64'(0));
            end else begin
                chk({name, "_valid"}, 64'(sdrsp_valid), 64'(1));
                chk({name, "_rsp"},   64'(sdrsp_rsp),   64'(x_rsp));
                chk({name, "_data"},  64'(sdrsp_data),  64'(x_data));
                chk({name, "_wr_en"}, 64'(blk_wr_en),   64'(x_wr));
                if (x_wr) chk({name, "_nxtst"}, 64'(blk_nxtSt), 64'(x_nxt));
            end
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        sureq_valid = 1'b0;
        sdrsp_ready = 1'b1;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            done = !m_busy && !sdrsp_valid;
            step();
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: snoop still outstanding after 12 cycles, sdrsp_valid=%0b", name, sdrsp_valid);
        end
    endtask

    initial begin
        // reset with a request pending
        rst = 1'b1;
        sureq_valid = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("reset_sureq_ready", 64'(sureq_ready), 64'(0));
        chk("reset_tag_rd_en",   64'(tag_rd_en),   64'(0));
        step();
        rst = 1'b0; sureq_valid = 1'b0; req_lock = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(sureq_ready), 64'(1));

        snoop("rd_mod", SUREQ_RD, 32'h40, 1'b1, MODIFIED, 32'hDEADBEEF,
              SDRSP_DATA, 32'hDEADBEEF, 1'b1, SHARED, 3);

        // RFO on EXCLUSIVE with the bus stalling four cycles
        step();
        sureq_valid = 1'b1; sureq_op = SUREQ_RFO; sureq_addr = 32'h80;
        plan_hit = 1'b1; plan_st = EXCLUSIVE; plan_data = 32'h12345678; sdrsp_ready = 1'b0;
        @(negedge clk);
        chk("rfo_tag_rd_en", 64'(tag_rd_en), 64'(1));
        for (int c = 1; c <= 6; c++) begin
            step();
            sureq_valid = 1'b0;
            sdrsp_ready = (c == 6);
            @(negedge clk);
            if (c < (FWD ? 3 : 2)) begin
                chk("rfo_early_valid", 64'(sdrsp_valid), 64'(0));
            end else begin
                chk("rfo_valid", 64'(sdrsp_valid), 64'(1));
                chk("rfo_rsp",   64'(sdrsp_rsp),   FWD ? 64'(SDRSP_DATA) : 64'(SDRSP_OKAY));
                chk("rfo_data",  64'(sdrsp_data),  FWD ? 64'h12345678 : 64'(0));
                chk("rfo_wr_en", 64'(blk_wr_en),   64'(c == 6));
                if (c == 6) chk("rfo_nxtst", 64'(blk_nxtSt), 64'(INVALID));
            end
        end

        snoop("inv_miss", SUREQ_INV, 32'hC0, 1'b0, MODIFIED, 32'h1111,
              SDRSP_MISS, 32'h0, 1'b0, INVALID, 2);
        snoop("inv_dirty", SUREQ_INV, 32'h200, 1'b1, MODIFIED, 32'h5555,
              SDRSP_OKAY, 32'h0, 1'b1, INVALID, 2);
        snoop("rfo_hit_invalid", SUREQ_RFO, 32'h280, 1'b1, INVALID, 32'h6666,
              SDRSP_MISS, 32'h0, 1'b0, INVALID, 2);
        snoop("rd_shared", SUREQ_RD, 32'h240, 1'b1, SHARED, 32'h7777,
              FWD ? SDRSP_DATA : SDRSP_OKAY, FWD ? 32'h7777 : 32'h0, 1'b1, SHARED, FWD ? 3 : 2);

        // req_lock holds off acceptance; lock rising mid-snoop is ignored
        step();
        req_lock = 1'b1; sureq_valid = 1'b1; sureq_op = SUREQ_RD; sureq_addr = 32'h100;
        plan_hit = 1'b1; plan_st = SHARED; plan_data = 32'h2222; sdrsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lock_ready",  64'(sureq_ready), 64'(0));
            chk("lock_tag_en", 64'(tag_rd_en),   64'(0));
            step();
        end
        req_lock = 1'b0;
        @(negedge clk);
        chk("unlock_tag_en",   64'(tag_rd_en),   64'(1));
        chk("unlock_tag_addr", 64'(tag_rd_addr), 64'h100);
        step();
        sureq_valid = 1'b0;
        req_lock = 1'b1;
        drain("lock");
        req_lock = 1'b0;

        // reset while the data read is in flight
        step();
        sureq_valid = 1'b1; sureq_op = SUREQ_RD; sureq_addr = 32'h140;
        plan_hit = 1'b1; plan_st = MODIFIED; plan_data = 32'hCAFEF00D; sdrsp_ready = 1'b1;
        @(negedge clk);
        step();
        sureq_valid = 1'b0;
        @(negedge clk);
        chk("abort_data_rd_en", 64'(data_rd_en), 64'(1));
        step();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(sdrsp_valid), 64'(0));
            chk("abort_no_wr",    64'(blk_wr_en),   64'(0));
            step();
        end
        snoop("post_abort", SUREQ_RD, 32'h180, 1'b1, MIGRATED, 32'h0BADCAFE,
              SDRSP_DATA, 32'h0BADCAFE, 1'b1, SHARED, 3);

        // randomized stream: requests held until accepted, random lock/stall, rare resets
        sureq_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 499) == 0);
            if (!sureq_valid || acc_last) begin
                sureq_valid = ($urandom_range(0, 9) < 6);
                sureq_op    = 2'($urandom_range(0, 2));
                sureq_addr  = AW'($urandom);
                plan_hit    = ($urandom_range(0, 3) != 0);
                plan_st     = 3'($urandom_range(0, 4));
                plan_data   = DW'($urandom);
            end
            req_lock    = ($urandom_range(0, 4) == 0);
            sdrsp_ready = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        req_lock = 1'b0;
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
